// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants and out-stage encoding for the dual-port-RAM FIFO controller.
package dpram_fifo_ctrl_pkg;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // Numeric value equals the number of entries held in the output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } out_state_e;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Streaming handshake bundle: upstream write side (s_*) and downstream read side (m_*).
interface dpram_fifo_ctrl_if;
  import dpram_fifo_ctrl_pkg::*;

  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  // The FIFO is the slave of both streams; the producer/consumer side is the master.
  modport slave  (input  s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
  modport master (output s_data, s_valid, m_ready, input  s_ready, m_data, m_valid);

endinterface

// File: rtl/dpram_fifo_ctrl_fifo_out_skid.sv
// Two-entry ordered output buffer that absorbs the RAM's registered read latency.
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | nothing held, m_valid low
//   ONE   | head valid
//   TWO   | head and tail valid, tail moves up on pop
module fifo_out_skid
  import dpram_fifo_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          capture_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  output logic [1:0]    occ_o
);

  out_state_e    state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          pop;

  assign m_valid_o = (state_q != EMPTY);
  assign m_data_o  = head_q;
  assign occ_o     = state_q;
  assign pop       = m_valid_o & m_ready_i;

  // State and data registers; reset clears head so m_data reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state and data movement for capture/pop combinations.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (capture_i) begin
          state_d = ONE;
          head_d  = cap_data_i;
        end
        ONE: begin
          if (capture_i && pop) begin
            head_d = cap_data_i;
          end else if (capture_i) begin
            state_d = TWO;
            tail_d  = cap_data_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          head_d = tail_q;
          if (capture_i) tail_d = cap_data_i;
          else           state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FWFT FIFO controller around a 16 x 9 dual-port RAM with registered port-B reads.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  dpram_fifo_ctrl_if.slave     bus,
  output logic [AW-1:0]        ram_addr_a,
  output logic [DW-1:0]        ram_din_a,
  output logic                 ram_we_a,
  output logic [AW-1:0]        ram_addr_b,
  output logic [DW-1:0]        ram_din_b,
  output logic                 ram_we_b,
  input  logic [DW-1:0]        ram_dout_b,
  output logic [AW+1:0]        count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW+1:0] count_q, count_d;

  logic          s_ready;
  logic          push, pop, rd_en;
  logic [1:0]    occ;
  logic [2:0]    demand;
  logic [DW-1:0] m_data;
  logic          m_valid;

  // s_ready depends only on registered state, never on the downstream side.
  assign s_ready     = (ram_cnt_q < DEPTH_C);
  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data;
  assign bus.m_valid = m_valid;

  assign push  = bus.s_valid & s_ready & ~flush;
  assign pop   = m_valid & bus.m_ready;

  // A read is only issued if its data will have room in the out stage when it lands.
  assign demand = {1'b0, occ} + {2'b00, rd_pend_q};
  assign rd_en  = (ram_cnt_q != '0) && (demand < (3'd2 + {2'b00, pop}));

  assign ram_addr_a = wr_ptr_q;
  assign ram_din_a  = bus.s_data;
  assign ram_we_a   = push & ~rst;
  assign ram_addr_b = rd_ptr_q;
  assign ram_din_b  = '0;
  assign ram_we_b   = 1'b0;
  assign count      = count_q;

  // Pointer, occupancy and in-flight-read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
    end
  end

  // Next-state: total count tracks push minus pop, which equals ram_cnt + rd_pend + occ.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{(AW-1){1'b0}}, rd_en};
    ram_cnt_d = ram_cnt_q;
    rd_pend_d = rd_en;
    count_d   = count_q;
    unique case ({push, rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + (AW+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (AW+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+2)'(1);
      2'b01:   count_d = count_q - (AW+2)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      rd_pend_d = 1'b0;
      count_d   = '0;
    end
  end

  fifo_out_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .capture_i  (rd_pend_q),
    .cap_data_i (ram_dout_b),
    .m_ready_i  (bus.m_ready),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .occ_o      (occ)
  );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read RAM on the ram_* pins.
module tb_dpram_fifo_ctrl;
  import dpram_fifo_ctrl_pkg::*;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_b;
  logic          ram_we_a, ram_we_b;
  logic [AW+1:0] count;

  dpram_fifo_ctrl_if bus ();

  dpram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_a   (ram_we_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_b  (ram_din_b),
    .ram_we_b   (ram_we_b),
    .ram_dout_b (ram_dout_b),
    .count      (count)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] q [$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample before the edge, update the model, then check count after it.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic push, pop;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = r;
    flush       = f;
    #1;
    if (prev_hold) chk("hold_stable", {22'd0, bus.m_valid, bus.m_data}, {22'd0, 1'b1, prev_data});
    push = v & bus.s_ready & ~f;
    pop  = bus.m_valid & r;
    if (f) q.delete();
    else if (pop) begin
      if (q.size() == 0) chk("underflow", 32'(bus.m_valid), 32'd0);
      else begin
        chk("m_data", 32'(bus.m_data), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    if (push) q.push_back(d);
    prev_hold = bus.m_valid & ~r & ~f;
    prev_data = bus.m_data;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(q.size()));
  endtask

  // The out stage must never see a capture while full and not popping.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      assert (!(dut.u_skid.state_q == TWO && dut.u_skid.capture_i && !dut.u_skid.pop)) else begin
        miscompares++;
        $error("FAIL skid_overflow observed=capture_in_TWO expected=none");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 9'h1FF;
    bus.m_ready = 1'b0;
    #2;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data",  32'(bus.m_data),  32'd0);
    chk("rst_count",   32'(count),       32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_we_a",    32'(ram_we_a),    32'd0);
    chk("rst_we_b",    32'(ram_we_b),    32'd0);
    chk("rst_din_b",   32'(ram_din_b),   32'd0);
    @(posedge clk);
    #1;
    chk("rst_we_a_edge", 32'(ram_we_a), 32'd0);
    chk("rst_count_edge", 32'(count), 32'd0);
    bus.s_valid = 1'b0;
    rst = 1'b0;

    // Single push: data appears two edges after accept.
    bus.s_valid = 1'b1;
    bus.s_data  = 9'h1A5;
    #1;
    chk("we_a_push",   32'(ram_we_a),   32'd1);
    chk("addr_a_push", 32'(ram_addr_a), 32'd0);
    cyc(1'b1, 9'h1A5, 1'b1, 1'b0);
    chk("lat_e0_valid", 32'(bus.m_valid), 32'd0);
    chk("lat_e0_count", 32'(count), 32'd1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("lat_e1_valid", 32'(bus.m_valid), 32'd0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("lat_e2_valid", 32'(bus.m_valid), 32'd1);
    chk("lat_e2_data",  32'(bus.m_data),  32'h1A5);
    chk("lat_e2_count", 32'(count), 32'd1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("pop_valid", 32'(bus.m_valid), 32'd0);
    chk("pop_count", 32'(count), 32'd0);

    // Fill to DEPTH+2 with no pops, then drain one per cycle.
    for (int i = 0; i < 18; i++) begin
      chk("fill_s_ready", 32'(bus.s_ready), 32'd1);
      cyc(1'b1, 9'(i), 1'b0, 1'b0);
    end
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    chk("full_count",   32'(count), 32'd18);
    cyc(1'b1, 9'h1FF, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      chk("drain_valid", 32'(bus.m_valid), 32'd1);
      cyc(1'b0, 9'h000, 1'b1, 1'b0);
    end
    chk("drained_valid", 32'(bus.m_valid), 32'd0);

    // Continuous push/pop: no bubbles once primed, pointers wrap.
    for (int i = 0; i < 40; i++) begin
      chk("stream_valid", 32'(bus.m_valid), (i >= 3) ? 32'd1 : 32'd0);
      cyc(1'b1, 9'(9'h040 + 9'(i)), 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("stream_end_valid", 32'(bus.m_valid), 32'd0);

    // Irregular producer and consumer.
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 3) != 0, 9'(9'h080 + 9'(i)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 25; i++) cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("rand_end_valid", 32'(bus.m_valid), 32'd0);

    // Flush with five entries held and a read in flight.
    for (int i = 0; i < 5; i++) cyc(1'b1, 9'(9'h0A0 + 9'(i)), 1'b0, 1'b0);
    cyc(1'b1, 9'h0A5, 1'b1, 1'b0);
    chk("preflush_count", 32'(count), 32'd5);
    chk("preflush_pend",  32'(dut.rd_pend_q), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 9'h055;
    flush = 1'b1;
    #1;
    chk("flush_we_a", 32'(ram_we_a), 32'd0);
    cyc(1'b1, 9'h055, 1'b0, 1'b1);
    chk("flush_valid",   32'(bus.m_valid), 32'd0);
    chk("flush_count",   32'(count), 32'd0);
    chk("flush_s_ready", 32'(bus.s_ready), 32'd1);
    cyc(1'b1, 9'h0FF, 1'b1, 1'b0);
    chk("flush_no_stale", 32'(bus.m_valid), 32'd0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("postflush_valid", 32'(bus.m_valid), 32'd1);
    chk("postflush_data",  32'(bus.m_data), 32'h0FF);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of streaming.
    for (int i = 0; i < 4; i++) cyc(1'b1, 9'(9'h0C0 + 9'(i)), 1'b0, 1'b0);
    bus.s_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid",   32'(bus.m_valid), 32'd0);
    chk("arst_data",    32'(bus.m_data),  32'd0);
    chk("arst_count",   32'(count),       32'd0);
    chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("arst_we_a",    32'(ram_we_a),    32'd0);
    q.delete();
    prev_hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    cyc(1'b1, 9'h123, 1'b1, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("postrst_valid", 32'(bus.m_valid), 32'd1);
    chk("postrst_data",  32'(bus.m_data),  32'h123);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("postrst_empty", 32'(bus.m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
